// File: rtl/jk_register_bank.sv
// Bank of WIDTH JK flip-flops with a shared mode select: per-bit JK, D or T
// operation, or whole-bank up/down counting with a registered wrap pulse.
module jk_register_bank #(
    parameter int unsigned      WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] notQ,
    output logic             wrap
);

    typedef enum logic [1:0] {
        ModeJk    = 2'b00,
        ModeD     = 2'b01,
        ModeT     = 2'b10,
        ModeCount = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] One = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;

    mode_e            w_mode;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic             w_cnt_up;
    logic             w_cnt_dn;
    logic             w_all_ones;
    logic             w_all_zero;
    logic [WIDTH-1:0] w_q_inc;
    logic [WIDTH-1:0] w_q_dec;

    assign w_mode     = mode_e'(mode);

    // Counting only looks at bit 0 of J/K; equal inputs mean hold.
    assign w_cnt_up   = J[0] & ~K[0];
    assign w_cnt_dn   = ~J[0] & K[0];
    assign w_all_ones = &r_q;
    assign w_all_zero = ~|r_q;
    assign w_q_inc    = r_q + One;
    assign w_q_dec    = r_q - One;

    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (en) begin
            unique case (w_mode)
                ModeJk: w_q_next = (J & ~r_q) | (~K & r_q);
                ModeD:  w_q_next = J;
                ModeT:  w_q_next = r_q ^ J;
                ModeCount: begin
                    if (w_cnt_up) begin
                        w_q_next    = w_q_inc;
                        w_wrap_next = w_all_ones;
                    end else if (w_cnt_dn) begin
                        w_q_next    = w_q_dec;
                        w_wrap_next = w_all_zero;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= RESET_VAL;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    // notQ is a pure inversion so it can never disagree with Q.
    assign Q    = r_q;
    assign notQ = ~r_q;
    assign wrap = r_wrap;

endmodule
